u_seqdiv: RTL and testbench

- Multicycle unsigned restoring divider; the inverse companion to the unsigned 8x8 array multipliers.
- Takes a 2N-bit dividend and an N-bit divisor. Returns an N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Valid/ready handshake on both input and output, so it can sit behind multiplier-based datapaths and in the self-check benches (q*d + r == dividend).

---
 rtl/u_seqdiv.sv | 143 ++++++++++++++
 tb/tb_u_seqdiv.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/u_seqdiv.sv
// Multicycle unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define U_SEQDIV_EARLY_EXIT_EN to bypass the CALC phase for divide-by-zero and overflow operands.
module u_seqdiv #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [N:0]    rem_r;
    logic [N-1:0]  quo_r;
    logic [N-1:0]  dvs_r;
    logic [N-1:0]  lo_r;
    logic          dbz_r;
    logic          ovf_r;
    logic [CW-1:0] count;

    logic          acc_dbz;
    logic          acc_ovf;
    logic          early;
    logic [N:0]    trial;
    logic          qbit;
    logic [N:0]    rem_nxt;
    logic [N-1:0]  quo_nxt;
    logic [N-1:0]  res_q;
    logic [N-1:0]  res_r;

    always_comb begin
        acc_dbz = (divisor == '0);
        acc_ovf = !acc_dbz && (dividend[2*N-1:N] >= divisor);
`ifdef U_SEQDIV_EARLY_EXIT_EN
        early   = acc_dbz || acc_ovf;
`else
        early   = 1'b0;
`endif
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial   = {rem_r[N-1:0], quo_r[N-1]};
        qbit    = (trial >= {1'b0, dvs_r});
        rem_nxt = qbit ? (trial - {1'b0, dvs_r}) : trial;
        quo_nxt = {quo_r[N-2:0], qbit};
    end

    // Exceptional operands override whatever the iteration produced.
    always_comb begin
        res_q = (dbz_r || ovf_r) ? '1 : quo_nxt;
        if (dbz_r)
            res_r = lo_r;
        else if (ovf_r)
            res_r = '0;
        else
            res_r = rem_nxt[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            count       <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            lo_r        <= '0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        dvs_r    <= divisor;
                        lo_r     <= dividend[N-1:0];
                        dbz_r    <= acc_dbz;
                        ovf_r    <= acc_ovf;
                        rem_r    <= {1'b0, dividend[2*N-1:N]};
                        quo_r    <= dividend[N-1:0];
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= early ? DONE : CALC;
                    end
                end
                CALC: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    count <= count + CW'(1);
                    if (count == CW'(N - 1)) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= res_q;
                        remainder   <= res_r;
                        div_by_zero <= dbz_r;
                        overflow    <= ovf_r;
                    end
                end
                DONE: begin
                    // Early-exit entry arrives with out_valid low; publish the forced result first.
                    if (!out_valid) begin
                        out_valid   <= 1'b1;
                        quotient    <= res_q;
                        remainder   <= res_r;
                        div_by_zero <= dbz_r;
                        overflow    <= ovf_r;
                    end else if (out_ready) begin
                        state       <= IDLE;
                        out_valid   <= 1'b0;
                        in_ready    <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        dbz_r       <= 1'b0;
                        ovf_r       <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_u_seqdiv.sv
// Directed and random checks for u_seqdiv with N = 8.
module tb_u_seqdiv;
    localparam int N = 8;
`ifdef U_SEQDIV_EARLY_EXIT_EN
    localparam int EXC_LAT = 1;
`else
    localparam int EXC_LAT = N;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    u_seqdiv #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair; returns just after the acceptance edge with operands scrambled.
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout in_ready=%b required 1", in_ready);
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic await_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL result_timeout out_valid=0 required 1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b required 1 0 00 00 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        int lat;
        out_ready = 1'b1;
        issue(16'h1234, 8'h56);
        await_result(lat);
        vectors++;
        if (lat !== N) begin
            miscompares++;
            $display("FAIL normal_latency got %0d required %0d", lat, N);
        end
        vectors++;
        if ({quotient, remainder, div_by_zero, overflow} !== {8'h36, 8'h10, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL normal_result got q=%h r=%h dbz=%b ovf=%b required 36 10 0 0",
                     quotient, remainder, div_by_zero, overflow);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL normal_busy in_ready=%b required 0", in_ready);
        end
        tick();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL normal_release got vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_max_legal();
        int lat;
        out_ready = 1'b1;
        issue(16'hFE01, 8'hFF);
        await_result(lat);
        vectors++;
        if ({lat, quotient, remainder, overflow, div_by_zero} !== {N, 8'hFF, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL max_legal got lat=%0d q=%h r=%h ovf=%b dbz=%b required %0d ff 00 0 0",
                     lat, quotient, remainder, overflow, div_by_zero, N);
        end
        tick();
    endtask

    task automatic test_div_by_zero();
        int lat;
        out_ready = 1'b1;
        issue(16'h00AB, 8'h00);
        await_result(lat);
        vectors++;
        if (lat !== EXC_LAT) begin
            miscompares++;
            $display("FAIL dbz_latency got %0d required %0d", lat, EXC_LAT);
        end
        vectors++;
        if ({quotient, remainder, div_by_zero, overflow} !== {8'hFF, 8'hAB, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL dbz_result got q=%h r=%h dbz=%b ovf=%b required ff ab 1 0",
                     quotient, remainder, div_by_zero, overflow);
        end
        tick();
        vectors++;
        if ({out_valid, div_by_zero, overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL dbz_flag_clear got vld=%b dbz=%b ovf=%b required 0 0 0", out_valid, div_by_zero, overflow);
        end
    endtask

    task automatic test_overflow();
        int lat;
        out_ready = 1'b1;
        issue(16'h1234, 8'h12);
        await_result(lat);
        vectors++;
        if (lat !== EXC_LAT) begin
            miscompares++;
            $display("FAIL ovf_latency got %0d required %0d", lat, EXC_LAT);
        end
        vectors++;
        if ({quotient, remainder, overflow, div_by_zero} !== {8'hFF, 8'h00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL ovf_result got q=%h r=%h ovf=%b dbz=%b required ff 00 1 0",
                     quotient, remainder, overflow, div_by_zero);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        issue(16'h0064, 8'h07);
        await_result(lat);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, 8'h0E, 8'h02}) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b q=%h r=%h required 1 0 0e 02",
                         i, out_valid, in_ready, quotient, remainder);
            end
            dividend = 16'h0FFF;
            divisor  = 8'h03;
            in_valid = (i % 2) == 1;
            tick();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if ({out_valid, in_ready, quotient, remainder} !== {1'b0, 1'b1, 8'h0E, 8'h02}) begin
            miscompares++;
            $display("FAIL bp_release got vld=%b rdy=%b q=%h r=%h required 0 1 0e 02",
                     out_valid, in_ready, quotient, remainder);
        end
        tick();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_idle got vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        issue(16'h1234, 8'h56);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b required 1 0 00 00 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        issue(16'h00FF, 8'h10);
        await_result(lat);
        vectors++;
        if ({lat, quotient, remainder} !== {N, 8'h0F, 8'h0F}) begin
            miscompares++;
            $display("FAIL reset_fresh got lat=%0d q=%h r=%h required %0d 0f 0f", lat, quotient, remainder, N);
        end
        tick();
    endtask

    task automatic test_boundaries();
        int lat;
        out_ready = 1'b1;
        issue(16'h0000, 8'h05);
        await_result(lat);
        vectors++;
        if ({quotient, remainder} !== 16'h0000) begin
            miscompares++;
            $display("FAIL zero_dividend got q=%h r=%h required 00 00", quotient, remainder);
        end
        tick();
        issue(16'h00C3, 8'h01);
        await_result(lat);
        vectors++;
        if ({quotient, remainder} !== {8'hC3, 8'h00}) begin
            miscompares++;
            $display("FAIL unit_divisor got q=%h r=%h required c3 00", quotient, remainder);
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        int a;
        int b;
        out_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            b = int'($urandom_range(1, 255));
            a = int'($urandom_range(0, b - 1)) * 256 + int'($urandom_range(0, 255));
            issue(16'(a), 8'(b));
            await_result(lat);
            vectors++;
            if ({quotient, remainder} !== {8'(a / b), 8'(a % b)}) begin
                miscompares++;
                $display("FAIL random_exact %0d/%0d got q=%0d r=%0d required q=%0d r=%0d",
                         a, b, quotient, remainder, a / b, a % b);
            end
            vectors++;
            if ((int'(quotient) * b + int'(remainder) != a) || (int'(remainder) >= b)) begin
                miscompares++;
                $display("FAIL random_identity %0d/%0d got q=%0d r=%0d required q*d+r==dividend and r<d",
                         a, b, quotient, remainder);
            end
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        test_reset();
        test_normal();
        test_max_legal();
        test_div_by_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_boundaries();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
